// File: rtl/pixel_stream_merge.sv
// N-lane round-robin pixel stream fan-in with a registered output beat and a
// frame barrier that holds finished lanes until every lane has sent its last beat.
module pixel_stream_merge #(
  parameter int N_LANES     = 4,
  parameter int DATA_W      = 32,
  parameter int FRAME_CNT_W = 16,
  localparam int LANE_W     = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_LANES-1:0]          s_valid,
  output logic [N_LANES-1:0]          s_ready,
  input  logic [N_LANES*DATA_W-1:0]   s_data,
  input  logic [N_LANES-1:0]          s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic [LANE_W-1:0]           m_lane,
  output logic                        m_frame_last,
  output logic [FRAME_CNT_W-1:0]      frame_count,
  output logic [N_LANES-1:0]          lanes_done
);

  localparam logic [LANE_W:0]   N_EXT     = (LANE_W+1)'(N_LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);

  logic                   r_mValid;
  logic [DATA_W-1:0]      r_mData;
  logic [LANE_W-1:0]      r_mLane;
  logic                   r_mFrameLast;
  logic [FRAME_CNT_W-1:0] r_frameCount;
  logic [N_LANES-1:0]     r_lanesDone;
  logic [LANE_W-1:0]      r_ptr;

  logic                   w_slotFree;
  logic [N_LANES-1:0]     w_eligible;
  logic                   w_found;
  logic [LANE_W-1:0]      w_grant;
  logic [N_LANES-1:0]     w_doneNext;
  logic [LANE_W-1:0]      w_ptrNext;
  logic [DATA_W-1:0]      w_selData;

  // Round-robin search: first eligible lane at or above ptr, wrapping to lane 0.
  always_comb begin
    w_slotFree = !r_mValid || m_ready;
    w_eligible = s_valid & ~r_lanesDone;
    w_found    = 1'b0;
    w_grant    = '0;
    for (int k = 0; k < N_LANES; k++) begin
      logic [LANE_W:0]   sum;
      logic [LANE_W-1:0] idx;
      sum = {1'b0, r_ptr} + (LANE_W+1)'(k);
      if (sum >= N_EXT) sum = sum - N_EXT;
      idx = sum[LANE_W-1:0];
      if (!w_found && w_eligible[idx]) begin
        w_found = 1'b1;
        w_grant = idx;
      end
    end
  end

  always_comb begin
    s_ready = '0;
    if (w_slotFree && w_found && !rst) s_ready[w_grant] = 1'b1;
    w_doneNext = r_lanesDone | (N_LANES'(1) << w_grant);
    w_ptrNext  = (w_grant == LAST_LANE) ? '0 : w_grant + 1'b1;
    w_selData  = s_data[int'(w_grant)*DATA_W +: DATA_W];
  end

  // Output slot, barrier bookkeeping and frame counter all advance on an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mValid     <= 1'b0;
      r_mData      <= '0;
      r_mLane      <= '0;
      r_mFrameLast <= 1'b0;
      r_frameCount <= '0;
      r_lanesDone  <= '0;
      r_ptr        <= '0;
    end else if (w_slotFree) begin
      if (w_found) begin
        r_mValid <= 1'b1;
        r_mData  <= w_selData;
        r_mLane  <= w_grant;
        r_ptr    <= w_ptrNext;
        if (s_last[w_grant]) begin
          if (&w_doneNext) begin
            r_mFrameLast <= 1'b1;
            r_lanesDone  <= '0;
            r_frameCount <= r_frameCount + 1'b1;
          end else begin
            r_mFrameLast <= 1'b0;
            r_lanesDone  <= w_doneNext;
          end
        end else begin
          r_mFrameLast <= 1'b0;
        end
      end else begin
        r_mValid <= 1'b0;
      end
    end
  end

  assign m_valid      = r_mValid;
  assign m_data       = r_mData;
  assign m_lane       = r_mLane;
  assign m_frame_last = r_mFrameLast;
  assign frame_count  = r_frameCount;
  assign lanes_done   = r_lanesDone;

endmodule

// File: tb/tb_pixel_stream_merge.sv
// Directed bench for pixel_stream_merge: a vector table for reset, round-robin,
// backpressure and frame barrier, plus hand sequences for mid-frame reset and counter wrap.
module tb_pixel_stream_merge;

  localparam int NL  = 4;
  localparam int DW  = 32;
  localparam int FCW = 2;

  logic              clk;
  logic              rst;
  logic [NL-1:0]     s_valid;
  logic [NL-1:0]     s_ready;
  logic [NL*DW-1:0]  s_data;
  logic [NL-1:0]     s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic [1:0]        m_lane;
  logic              m_frame_last;
  logic [FCW-1:0]    frame_count;
  logic [NL-1:0]     lanes_done;

  int testCount = 0;
  int failCount = 0;

  pixel_stream_merge #(.N_LANES(NL), .DATA_W(DW), .FRAME_CNT_W(FCW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_lane(m_lane),
    .m_frame_last(m_frame_last), .frame_count(frame_count), .lanes_done(lanes_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        mReady;
    logic [3:0]  expReady;
    logic        expMValid;
    logic        chkData;
    logic [1:0]  expLane;
    logic [31:0] expData;
    logic        expFl;
    logic [3:0]  expDone;
    logic [1:0]  expCount;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mkVec(logic r, logic [3:0] v, logic [3:0] l, logic mr,
                                 logic [3:0] er, logic emv, logic chk, logic [1:0] el,
                                 logic [31:0] ed, logic efl, logic [3:0] edn, logic [1:0] ec);
    vec_t t;
    t.rst = r; t.valid = v; t.last = l; t.mReady = mr;
    t.expReady = er; t.expMValid = emv; t.chkData = chk; t.expLane = el;
    t.expData = ed; t.expFl = efl; t.expDone = edn; t.expCount = ec;
    return t;
  endfunction

  // Inputs change on the falling edge; lane i carries step*256+i as payload.
  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [3:0] l,
                               input logic mr, input int step);
    @(negedge clk);
    rst = r; s_valid = v; s_last = l; m_ready = mr;
    for (int i = 0; i < NL; i++) s_data[i*DW +: DW] = DW'(step * 256 + i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic waitAfterEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int flPulses;
    rst = 1'b1; s_valid = '0; s_last = '0; m_ready = 1'b1; s_data = '0;

    vecs[0]  = mkVec(1, 4'hF, 4'h0, 1, 4'h0, 0, 1, 0, 32'h0,    0, 4'h0, 0);
    vecs[1]  = mkVec(1, 4'hF, 4'h0, 1, 4'h0, 0, 1, 0, 32'h0,    0, 4'h0, 0);
    vecs[2]  = mkVec(1, 4'hF, 4'h0, 1, 4'h0, 0, 1, 0, 32'h0,    0, 4'h0, 0);
    vecs[3]  = mkVec(0, 4'hF, 4'h0, 1, 4'h1, 1, 1, 0, 32'h300,  0, 4'h0, 0);
    vecs[4]  = mkVec(0, 4'hF, 4'h0, 1, 4'h2, 1, 1, 1, 32'h401,  0, 4'h0, 0);
    vecs[5]  = mkVec(0, 4'hF, 4'h0, 1, 4'h4, 1, 1, 2, 32'h502,  0, 4'h0, 0);
    vecs[6]  = mkVec(0, 4'hF, 4'h0, 1, 4'h8, 1, 1, 3, 32'h603,  0, 4'h0, 0);
    vecs[7]  = mkVec(0, 4'hF, 4'h0, 1, 4'h1, 1, 1, 0, 32'h700,  0, 4'h0, 0);
    vecs[8]  = mkVec(0, 4'hF, 4'h0, 1, 4'h2, 1, 1, 1, 32'h801,  0, 4'h0, 0);
    vecs[9]  = mkVec(0, 4'hF, 4'h0, 0, 4'h0, 1, 1, 1, 32'h801,  0, 4'h0, 0);
    vecs[10] = mkVec(0, 4'hF, 4'h0, 0, 4'h0, 1, 1, 1, 32'h801,  0, 4'h0, 0);
    vecs[11] = mkVec(0, 4'hF, 4'h0, 0, 4'h0, 1, 1, 1, 32'h801,  0, 4'h0, 0);
    vecs[12] = mkVec(0, 4'hF, 4'h0, 1, 4'h4, 1, 1, 2, 32'hC02,  0, 4'h0, 0);
    vecs[13] = mkVec(0, 4'hF, 4'h0, 1, 4'h8, 1, 1, 3, 32'hD03,  0, 4'h0, 0);
    vecs[14] = mkVec(0, 4'h2, 4'h2, 1, 4'h2, 1, 1, 1, 32'hE01,  0, 4'h2, 0);
    vecs[15] = mkVec(0, 4'hF, 4'h0, 1, 4'h4, 1, 1, 2, 32'hF02,  0, 4'h2, 0);
    vecs[16] = mkVec(0, 4'hF, 4'h8, 1, 4'h8, 1, 1, 3, 32'h1003, 0, 4'hA, 0);
    vecs[17] = mkVec(0, 4'hF, 4'h1, 1, 4'h1, 1, 1, 0, 32'h1100, 0, 4'hB, 0);
    vecs[18] = mkVec(0, 4'hF, 4'h4, 1, 4'h4, 1, 1, 2, 32'h1202, 1, 4'h0, 1);
    vecs[19] = mkVec(0, 4'h2, 4'h0, 1, 4'h2, 1, 1, 1, 32'h1301, 0, 4'h0, 1);
    vecs[20] = mkVec(0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 32'h0,    0, 4'h0, 1);

    // Table: reset, round-robin, backpressure hold, frame barrier and release.
    for (int s = 0; s < 21; s++) begin
      applyStimulus(vecs[s].rst, vecs[s].valid, vecs[s].last, vecs[s].mReady, s);
      checkOutput($sformatf("s_ready[%0d]", s), 32'(s_ready), 32'(vecs[s].expReady));
      waitAfterEdge();
      checkOutput($sformatf("m_valid[%0d]", s), 32'(m_valid), 32'(vecs[s].expMValid));
      checkOutput($sformatf("lanes_done[%0d]", s), 32'(lanes_done), 32'(vecs[s].expDone));
      checkOutput($sformatf("frame_count[%0d]", s), 32'(frame_count), 32'(vecs[s].expCount));
      if (vecs[s].chkData) begin
        checkOutput($sformatf("m_lane[%0d]", s), 32'(m_lane), 32'(vecs[s].expLane));
        checkOutput($sformatf("m_data[%0d]", s), m_data, vecs[s].expData);
        checkOutput($sformatf("m_frame_last[%0d]", s), 32'(m_frame_last), 32'(vecs[s].expFl));
      end
    end

    // Mid-frame reset: build lanes_done=0101 with a beat held under backpressure.
    applyStimulus(1, 4'h0, 4'h0, 1, 100);
    waitAfterEdge();
    applyStimulus(0, 4'h1, 4'h1, 1, 101);
    waitAfterEdge();
    applyStimulus(0, 4'h4, 4'h4, 1, 102);
    waitAfterEdge();
    applyStimulus(0, 4'h0, 4'h0, 0, 103);
    waitAfterEdge();
    checkOutput("mid held m_valid", 32'(m_valid), 32'd1);
    checkOutput("mid held lanes_done", 32'(lanes_done), 32'h5);
    applyStimulus(1, 4'hF, 4'h0, 0, 104);
    checkOutput("mid rst s_ready", 32'(s_ready), 32'h0);
    waitAfterEdge();
    applyStimulus(0, 4'h0, 4'h0, 0, 105);
    waitAfterEdge();
    checkOutput("mid after m_valid", 32'(m_valid), 32'd0);
    checkOutput("mid after lanes_done", 32'(lanes_done), 32'h0);
    checkOutput("mid after frame_count", 32'(frame_count), 32'd0);

    // Four full frames on a 2-bit counter: 1,2,3,0 with one frame_last each.
    flPulses = 0;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NL; k++) begin
        applyStimulus(0, 4'hF, 4'hF, 1, 200 + f*4 + k);
        checkOutput($sformatf("wrap s_ready f%0d k%0d", f, k), 32'(s_ready), 32'(1 << k));
        waitAfterEdge();
        if (m_frame_last) flPulses++;
        checkOutput($sformatf("wrap m_lane f%0d k%0d", f, k), 32'(m_lane), 32'(k));
        checkOutput($sformatf("wrap m_frame_last f%0d k%0d", f, k), 32'(m_frame_last),
                    (k == NL-1) ? 32'd1 : 32'd0);
        checkOutput($sformatf("wrap frame_count f%0d k%0d", f, k), 32'(frame_count),
                    (k == NL-1) ? 32'((f + 1) % 4) : 32'(f % 4));
      end
    end
    checkOutput("wrap frame_last pulses", 32'(flPulses), 32'd4);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
